sprite_bitmap_loader: RTL and testbench
=======================================

// Module: sprite_bitmap_loader
// PURPOSE
//  Write side of the sprite bitmap interface: accepts a byte stream of sprite rows
//  and stores it in a double-buffered 8-bit x ROWS bitmap RAM.
//  Renderers read the front buffer through the same yofs->bits port a bitmap ROM
//  exposes; the back buffer is swapped in only at a vsync rising edge (tear-free).
//  Sits between a CPU/UART byte source and a sprite renderer, in place of a fixed ROM.
// PARAMETERS
//  ROWS    16  sprite height in rows; must be a power of two, 2..64
//  YBITS    4  row index width, = log2(ROWS)
// PORTS
//  clk           in   1      pixel clock, the design's single clock
//  reset         in   1      synchronous, active-high
//  vsync         in   1      from hvsync_generator; a rising edge is a swap opportunity
//  wr_valid      in   1      source presents a row byte
//  wr_data       in   8      row bits; bit0 = rightmost pixel, same as ROM layout
//  wr_ready      out  1      loader accepts a byte this cycle
//  yofs          in   YBITS  renderer row select
//  bits          out  8      front-buffer row yofs, combinational (ROM-equivalent)
//  frame_swapped out  1      one-cycle pulse: front/back exchanged this cycle
//  back_full     out  1      back buffer holds a complete sprite awaiting swap
// BEHAVIOUR
//  - Reset, while asserted: both banks are cleared to 0, row_cnt=0, front=0, and
//    state=LOAD. vsync_d is set to 1 so a vsync already high is not taken as an edge.
//    Outputs: frame_swapped=0, back_full=0, bits=0; wr_ready is 0 during reset and
//    1 from the first cycle after reset.
//  - Reset mid-load discards any partial back buffer and the front contents; there is
//    no partial swap.
//  - Transfer happens when wr_valid && wr_ready on a posedge clk. The byte goes to
//    back[row_cnt]. row_cnt increments and wraps from ROWS-1 to 0.
//  - wr_data may change freely when wr_valid=0. The source must hold wr_data stable
//    while wr_valid=1 && wr_ready=0.
//  - FSM, 2 states:
//     LOAD : wr_ready=1. The transfer that writes row ROWS-1 moves to FULL on the next cycle.
//     FULL : wr_ready=0, back_full=1. When vs_edge = vsync && !vsync_d, in that
//            cycle: front <= ~front, frame_swapped <= 1 (visible the following cycle),
//            and state <= LOAD with row_cnt=0.
//  - A vs_edge while in LOAD, including in the cycle that writes the last row, is
//    ignored; the swap waits for the next vs_edge after reaching FULL.
//  - Latency: the last byte is accepted at cycle N. The earliest swap is at the first
//    vs_edge at or after N+1. bits reflects the new data in the cycle after that edge.
//  - bits = bank[front][yofs], asynchronous read, with no dependence on the write port.
//    A write never alters the front bank, so a renderer indexing by yofs mid-line never
//    sees a torn row.
//  - back_full = (state==FULL). It is registered via the state flop and is glitch-free.
//  - vsync_d is a plain register. vsync is assumed synchronous to clk, so no
//    synchroniser is used.
// STRUCTURE
//  - Shared package sprite_pkg: ROWS/YBITS defaults, SPR_W=8, LOAD/FULL state encodings.
//  - Sub-module sprite_bitmap_bank: 2 x ROWS x 8 register array, with one sync write
//    port (bank, addr, data, we) and one async read port (bank, addr). Clear on reset.
//  - The top level holds the FSM, row_cnt, front, vsync_d and the pulse register.
// TESTING
//  1. Reset, then read yofs=0..15 -> bits=0 everywhere. wr_ready=1 on the first
//     cycle after reset; back_full=0.
//  2. Stream 16 bytes 8'h00,8'h0C,8'hCC,... back-to-back. Then pulse vsync ->
//     wr_ready=0 after the 16th byte, and back_full=1 until the edge.
//     frame_swapped is high exactly 1 cycle after the edge; bits[yofs=2]=8'hCC afterwards.
//  3. Before any vsync, read during load -> front still shows the old data (all 0).
//     Bytes offered while FULL are not taken: wr_ready=0 and row_cnt holds.
//  4. vsync rising in the same cycle as the 16th byte -> no swap. The swap occurs on
//     the next vsync rise; exactly one frame_swapped pulse.
//  5. Hold vsync high through reset release -> no swap, even once back_full=1.
//     The swap occurs only after vsync falls and rises again.
//  6. Assert reset after 7 bytes of a 2nd frame (front holds frame 1) -> bits=0 for
//     all rows and row_cnt=0. A fresh 16-byte load plus a vsync edge swaps cleanly.
//     Also use random wr_valid gaps, with a scoreboard checking row order.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes and FSM encodings for the sprite bitmap loader.
package sprite_pkg;
    localparam int SPR_ROWS  = 16;
    localparam int SPR_YBITS = 4;
    localparam int SPR_W     = 8;
    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] FULL = 1'b1;
endpackage

// File: rtl/sprite_bitmap_bank.sv
// sprite_bitmap_bank: two banks of ROWS x 8 registers, one sync write port, one async read port.
module sprite_bitmap_bank
    import sprite_pkg::*;
#(
    parameter int ROWS  = SPR_ROWS,
    parameter int YBITS = SPR_YBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [YBITS-1:0] wr_addr,
    input  logic [SPR_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [YBITS-1:0] rd_addr,
    output logic [SPR_W-1:0] rd_data
);
    logic [SPR_W-1:0] mem [2][ROWS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    mem[b][r] <= '0;
        end else if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];
endmodule

// File: rtl/sprite_bitmap_loader.sv
// sprite_bitmap_loader: streams sprite row bytes into a back buffer and swaps it to the
// renderer-facing front buffer only on a vsync rising edge.
module sprite_bitmap_loader
    import sprite_pkg::*;
#(
    parameter int ROWS  = SPR_ROWS,
    parameter int YBITS = SPR_YBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             wr_valid,
    input  logic [SPR_W-1:0] wr_data,
    output logic             wr_ready,
    input  logic [YBITS-1:0] yofs,
    output logic [SPR_W-1:0] bits,
    output logic             frame_swapped,
    output logic             back_full
);
    logic [0:0]       state;
    logic [YBITS-1:0] row_cnt;
    logic             front;
    logic             vsync_d;
    logic [SPR_W-1:0] rd_bits;
    logic             xfer;
    logic             vs_edge;

    assign wr_ready  = !reset && state == LOAD;
    assign back_full = state == FULL;
    assign xfer      = wr_valid && wr_ready;
    assign vs_edge   = vsync && !vsync_d;
    assign bits      = reset ? '0 : rd_bits;

    sprite_bitmap_bank #(.ROWS(ROWS), .YBITS(YBITS)) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (xfer),
        .wr_bank (~front),
        .wr_addr (row_cnt),
        .wr_data (wr_data),
        .rd_bank (front),
        .rd_addr (yofs),
        .rd_data (rd_bits)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= LOAD;
            row_cnt       <= '0;
            front         <= 1'b0;
            vsync_d       <= 1'b1;
            frame_swapped <= 1'b0;
        end else begin
            vsync_d       <= vsync;
            frame_swapped <= 1'b0;
            if (xfer) begin
                row_cnt <= row_cnt + 1'b1;
                if (row_cnt == YBITS'(ROWS - 1))
                    state <= FULL;
            end
            // Edges seen while still loading are dropped; only a completed back buffer swaps.
            if (state == FULL && vs_edge) begin
                front         <= ~front;
                frame_swapped <= 1'b1;
                state         <= LOAD;
                row_cnt       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sprite_bitmap_loader.sv
// tb_sprite_bitmap_loader: directed frames with a scoreboard that checks the whole front
// buffer every time a swap pulse or a probe request appears.
module tb_sprite_bitmap_loader;
    typedef logic [15:0][7:0] frame_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic [3:0] yofs = 4'd0;
    logic [7:0] bits;
    logic       frame_swapped;
    logic       back_full;

    logic       probe = 1'b0;
    frame_t     exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         swap_cnt = 0;

    frame_t     fz, fa, fb, fc, fd;
    logic [7:0] a_rows [16] = '{8'h00, 8'h0C, 8'hCC, 8'hFC, 8'hFF, 8'h3F, 8'h33, 8'h30,
                                8'h00, 8'h81, 8'h42, 8'h24, 8'h18, 8'hA5, 8'h5A, 8'h01};

    sprite_bitmap_loader dut (
        .clk           (clk),
        .reset         (reset),
        .vsync         (vsync),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .yofs          (yofs),
        .bits          (bits),
        .frame_swapped (frame_swapped),
        .back_full     (back_full)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: owns yofs, sweeps every row whenever a swap pulse or probe shows up.
    initial begin
        frame_t e;
        forever begin
            @(negedge clk);
            if (frame_swapped === 1'b1) swap_cnt++;
            if (frame_swapped === 1'b1 || probe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_front_event", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < 16; i++) begin
                        yofs = 4'(i);
                        #1;
                        chk($sformatf("bits_row%0d", i), 32'(bits), 32'(e[i]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_front(input frame_t f);
        exp_q.push_back(f);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit vs);
        int k;
        wr_data  = d;
        wr_valid = 1'b1;
        if (vs) vsync = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wr_ready && k < 50);
        if (!wr_ready) chk("accept_timeout", 0, 1);
        tick();
        if (vs) vsync = 1'b0;
    endtask

    task automatic send_rows(input frame_t f, input int lo, input int hi, input bit gaps, input bit vs_last);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                int r = int'($urandom_range(0, 2));
                wr_valid = 1'b0;
                repeat (r) tick();
            end
            send_byte(f[i], vs_last && i == hi);
        end
        wr_valid = 1'b0;
    endtask

    task automatic vs_swap(input frame_t f);
        exp_q.push_back(f);
        vsync = 1'b1;
        @(negedge clk);
        chk("swap_not_before_edge", 32'(frame_swapped), 0);
        tick();
        vsync = 1'b0;
        @(negedge clk);
        chk("swap_pulse", 32'(frame_swapped), 1);
        chk("back_full_after_swap", 32'(back_full), 0);
        chk("wr_ready_after_swap", 32'(wr_ready), 1);
        @(negedge clk);
        chk("swap_pulse_end", 32'(frame_swapped), 0);
        tick();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    initial begin
        int s;
        fz = '0;
        for (int i = 0; i < 16; i++) begin
            fa[i] = a_rows[i];
            fb[i] = {4'(i), ~4'(i)};
            fc[i] = 8'(i * 19 + 7);
            fd[i] = 8'(8'h80 >> (i % 8)) ^ 8'(i);
        end

        // 1: reset behaviour and cleared front
        tick();
        @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_back_full", 32'(back_full), 0);
        chk("rst_frame_swapped", 32'(frame_swapped), 0);
        chk("rst_bits", 32'(bits), 0);
        do_reset(2);
        @(negedge clk);
        chk("post_rst_wr_ready", 32'(wr_ready), 1);
        chk("post_rst_back_full", 32'(back_full), 0);
        tick();
        check_front(fz);

        // 2/3: load A back-to-back, refuse bytes while full, old front visible until swap
        send_rows(fa, 0, 15, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_wr_ready", 32'(wr_ready), 0);
        chk("full_back_full", 32'(back_full), 1);
        wr_data  = 8'hEE;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_refuses", 32'(wr_ready), 0);
        end
        tick();
        wr_valid = 1'b0;
        check_front(fz);
        vs_swap(fa);
        chk("swap_cnt_a", swap_cnt, 1);

        // 4: B with gaps; check front mid-load; vsync rises with the last byte (ignored)
        send_rows(fb, 0, 7, 1'b1, 1'b0);
        check_front(fa);
        send_rows(fb, 8, 15, 1'b1, 1'b1);
        @(negedge clk);
        chk("late_edge_no_swap", 32'(frame_swapped), 0);
        chk("late_edge_full", 32'(back_full), 1);
        repeat (3) tick();
        chk("swap_cnt_late_edge", swap_cnt, 1);
        vs_swap(fb);
        repeat (4) tick();
        chk("swap_cnt_b", swap_cnt, 2);

        // 5: vsync held high through reset release
        vsync = 1'b1;
        do_reset(2);
        send_rows(fc, 0, 15, 1'b1, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        chk("held_vsync_full", 32'(back_full), 1);
        chk("swap_cnt_held_vsync", swap_cnt, 2);
        tick();
        check_front(fz);
        vsync = 1'b0;
        tick();
        vs_swap(fc);
        chk("swap_cnt_c", swap_cnt, 3);

        // 6: reset after 7 bytes of D discards everything; fresh D load swaps in order
        send_rows(fd, 0, 6, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rst_bits", 32'(bits), 0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 0);
        tick();
        reset = 1'b0;
        tick();
        check_front(fz);
        send_rows(fd, 0, 15, 1'b1, 1'b0);
        vs_swap(fd);
        chk("swap_cnt_d", swap_cnt, 4);

        s = exp_q.size();
        repeat (2) tick();
        chk("scoreboard_drained", s, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
